// File: rtl/dca_matrix_step_issuer.sv
// dca_matrix_step_issuer
// Walks the (y, x, k) tile loop of one matrix instruction and issues one
// step per handshake to the MAC datapath. Each step is issued atomically:
// step_valid and every LSU channel request assert together, and only in the
// cycle where the datapath, all requested channels and the outstanding-step
// credit are ready. The instruction completes (inst_ready) once every issued
// step has reported step_done.
module dca_matrix_step_issuer #(
  parameter int NUM_SRC         = 2,
  parameter int BW_TILE_IDX     = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   rstnn,
  input  logic                   clear,
  input  logic                   enable,
  output logic                   busy,

  input  logic                   inst_valid,
  output logic                   inst_ready,
  input  logic [BW_TILE_IDX-1:0] inst_num_y,
  input  logic [BW_TILE_IDX-1:0] inst_num_x,
  input  logic [BW_TILE_IDX-1:0] inst_num_k,
  input  logic [2:0]             inst_opcode,

  output logic                   step_valid,
  input  logic                   step_ready,
  output logic                   step_first_k,
  output logic                   step_last_k,
  output logic                   step_init_acc,
  output logic                   step_load_acc,
  output logic                   step_compute,
  input  logic                   step_done,

  output logic [NUM_SRC-1:0]     src_req,
  input  logic [NUM_SRC-1:0]     src_ready,
  output logic                   dst_req,
  output logic                   dst_write,
  input  logic                   dst_ready,

  output logic [BW_TILE_IDX-1:0] cur_y,
  output logic [BW_TILE_IDX-1:0] cur_x,
  output logic [BW_TILE_IDX-1:0] cur_k
);

  localparam int                   OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0]     MAX_CNT = OUT_W'(MAX_OUTSTANDING);
  localparam logic [BW_TILE_IDX-1:0] ONE   = BW_TILE_IDX'(1);

  // Opcode bit positions.
  localparam int OP_INIT  = 0;
  localparam int OP_LOAD  = 1;
  localparam int OP_STORE = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t                  r_state;
  logic [BW_TILE_IDX-1:0]  r_num_y, r_num_x, r_num_k;
  logic [2:0]              r_opcode;
  logic [BW_TILE_IDX-1:0]  r_y, r_x, r_k;
  logic [OUT_W-1:0]        r_outstanding;

  logic w_first_k, w_last_k, w_last_x, w_last_y;
  logic w_credits_ok, w_run_dst, w_can_issue;
  logic w_fire_load, w_fire_run, w_fire, w_done_ok;

  // Loop-position flags and the fire decision for the pending step.
  always_comb begin
    // NOTE: every signal gets a default at the top of always_comb, so no path
    // can leave one unassigned and infer a latch.
    w_first_k    = 1'b0;
    w_last_k     = 1'b0;
    w_last_x     = 1'b0;
    w_last_y     = 1'b0;
    w_credits_ok = 1'b0;
    w_run_dst    = 1'b0;
    w_can_issue  = 1'b0;
    w_fire_load  = 1'b0;
    w_fire_run   = 1'b0;
    w_fire       = 1'b0;
    w_done_ok    = 1'b0;

    w_first_k    = (r_k == '0);
    w_last_k     = (r_k == r_num_k - ONE);
    w_last_x     = (r_x == r_num_x - ONE);
    w_last_y     = (r_y == r_num_y - ONE);
    // A done pulse in this cycle does not free a credit until the next edge.
    w_credits_ok = (r_outstanding < MAX_CNT);
    w_run_dst    = w_last_k & r_opcode[OP_STORE];
    w_can_issue  = enable & ~clear & step_ready & w_credits_ok;
    w_fire_load  = (r_state == ST_LOAD) & w_can_issue & dst_ready;
    w_fire_run   = (r_state == ST_RUN) & w_can_issue & (&src_ready)
                   & (~w_run_dst | dst_ready);
    w_fire       = w_fire_load | w_fire_run;
    // A stray done with nothing outstanding is dropped rather than wrapping.
    w_done_ok    = step_done & (r_outstanding != '0);
  end

  // Step and channel outputs exist only in the firing cycle.
  always_comb begin
    step_valid    = w_fire;
    src_req       = {NUM_SRC{w_fire_run}};
    dst_req       = w_fire_load | (w_fire_run & w_run_dst);
    dst_write     = w_fire_run & w_run_dst;
    step_load_acc = w_fire_load;
    step_compute  = w_fire_run;
    step_first_k  = w_fire_run & w_first_k;
    step_last_k   = w_fire_run & w_last_k;
    step_init_acc = w_fire_run & w_first_k & r_opcode[OP_INIT] & ~r_opcode[OP_LOAD];
    inst_ready    = (r_state == ST_DRAIN) & (r_outstanding == '0) & enable & ~clear;
    busy          = (r_state != ST_IDLE);
    cur_y         = r_y;
    cur_x         = r_x;
    cur_k         = r_k;
  end

  // Instruction FSM: accept, walk k inside x inside y, then drain.
  always_ff @(posedge clk or negedge rstnn) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (!rstnn) begin
      r_state  <= ST_IDLE;
      r_num_y  <= '0;
      r_num_x  <= '0;
      r_num_k  <= '0;
      r_opcode <= '0;
      r_y      <= '0;
      r_x      <= '0;
      r_k      <= '0;
    end else if (clear) begin
      r_state  <= ST_IDLE;
      r_num_y  <= '0;
      r_num_x  <= '0;
      r_num_k  <= '0;
      r_opcode <= '0;
      r_y      <= '0;
      r_x      <= '0;
      r_k      <= '0;
    end else if (enable) begin
      case (r_state)
        ST_IDLE: begin
          if (inst_valid) begin
            r_num_y  <= inst_num_y;
            r_num_x  <= inst_num_x;
            r_num_k  <= inst_num_k;
            r_opcode <= inst_opcode;
            r_y      <= '0;
            r_x      <= '0;
            r_k      <= '0;
            if ((inst_num_y == '0) || (inst_num_x == '0) || (inst_num_k == '0))
              r_state <= ST_DRAIN;
            else if (inst_opcode[OP_LOAD])
              r_state <= ST_LOAD;
            else
              r_state <= ST_RUN;
          end
        end
        ST_LOAD: begin
          if (w_fire) begin
            r_state <= ST_RUN;
            r_k     <= '0;
          end
        end
        ST_RUN: begin
          if (w_fire) begin
            if (w_last_k) begin
              r_k <= '0;
              if (w_last_x) begin
                r_x <= '0;
                if (w_last_y) begin
                  r_y     <= '0;
                  r_state <= ST_DRAIN;
                end else begin
                  r_y     <= r_y + ONE;
                  r_state <= r_opcode[OP_LOAD] ? ST_LOAD : ST_RUN;
                end
              end else begin
                r_x     <= r_x + ONE;
                r_state <= r_opcode[OP_LOAD] ? ST_LOAD : ST_RUN;
              end
            end else begin
              r_k <= r_k + ONE;
            end
          end
        end
        ST_DRAIN: begin
          if (r_outstanding == '0) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outstanding-step counter: +1 per fire, -1 per accepted done.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_outstanding <= '0;
    end else if (clear) begin
      r_outstanding <= '0;
    end else if (enable) begin
      case ({w_fire, w_done_ok})
        2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

endmodule
